ibex_multdiv_iter: RTL and testbench
====================================

IBEX_MULTDIV_ITER -- requirements
Module: ibex_multdiv_iter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk_i and rst_ni.
REQ-002 clk_i  input  1  rising-edge clock.
REQ-003 rst_ni  input  1  asynchronous active-low reset.
REQ-004 en_i  input  1  operation request; held high until valid_o.
REQ-005 operator_i  input  md_op_e  MD_OP_MULL, MD_OP_MULH, MD_OP_DIV, MD_OP_REM.
REQ-006 signed_mode_i  input  2  bit0 = op_a signed, bit1 = op_b signed.
REQ-007 op_a_i, op_b_i  input  32 each  multiplicand/dividend, multiplier/divisor.
REQ-008 alu_sel_o  output  1  high while the block owns the ALU adder.
REQ-009 alu_operand_a_o, alu_operand_b_o  output  33 each  adder inputs, formatted {x,1'b1} and {y,1'b0}; subtract uses ~{y,1'b0}.
REQ-010 adder_result_ext_i  input  34  ALU adder sum; sum = [32:1], carry = [33].
REQ-011 valid_o  output  1  result valid, one-cycle pulse.
REQ-012 result_o  output  32  result, valid only when valid_o is high.

Function
REQ-013 States SHALL be IDLE, ABS_A, ABS_B, CALC, NEG, FINISH; transitions IDLE->ABS_A (en_i=1), ABS_A->ABS_B->CALC, CALC->NEG after 32 iterations, NEG->FINISH->IDLE.
REQ-014 Latency SHALL be fixed: request accepted in IDLE at cycle T -> valid_o=1 at T+36 for every operator, including special cases.
REQ-015 ABS_A/ABS_B SHALL replace an operand with its magnitude (0 - x via adder) when its signed bit is set and bit 31 is 1; otherwise pass through, still spending the cycle.
REQ-016 alu_sel_o SHALL be 1 in ABS_A, ABS_B and CALC only; 0 otherwise.
REQ-017 Multiply CALC: 65-bit {carry,hi,lo} accumulator; each iteration adds the multiplicand to hi when lo[0]=1, then shifts right 1; iteration counter 5 bits, wraps 31->0 exiting CALC.
REQ-018 Divide CALC: restoring; shift {rem,quot} left 1, trial-subtract divisor via adder, keep on carry=1 and set quotient bit, else restore.
REQ-019 NEG SHALL two's-complement the 64-bit product when exactly one signed operand was negative; quotient when dividend and divisor signs differ; remainder when dividend negative (local negation logic, not the shared adder).
REQ-020 MD_OP_MULL returns product[31:0]; MD_OP_MULH returns product[63:32]; signed_mode_i selects MULH/MULHSU/MULHU.
REQ-021 Divide by zero, detected at acceptance: quotient 0xFFFFFFFF, remainder = op_a_i (signed and unsigned).
REQ-022 Signed overflow (0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0.
REQ-023 en_i low in any non-IDLE state SHALL abort: IDLE next cycle, no valid_o; operands re-latched on next request.
REQ-024 en_i held high in FINISH SHALL NOT restart; a new request is accepted only in IDLE.

Reset
REQ-025 rst_ni low SHALL asynchronously force state IDLE, counter 0, accumulators 0, valid_o 0, alu_sel_o 0, result_o 0, operand outputs 0.
REQ-026 Reset asserted mid-operation SHALL discard the operation; no valid_o after release until a new request.

Structure
REQ-027 md_op_e and md_state_e SHALL reside in ibex_defines.
REQ-028 The block SHALL be flat with no sub-module; the adder is shared with ibex_alu via alu_sel_o.

Verification
REQ-029 MULL 7 x 6, unsigned -> result_o 0x0000002A, valid_o exactly 36 cycles after acceptance.
REQ-030 MULH 0xFFFFFFFF x 0xFFFFFFFF: signed -> 0x00000000, MULHSU -> 0xFFFFFFFF, MULHU -> 0xFFFFFFFE; signed 0x80000000 x 0x80000000 -> 0x40000000.
REQ-031 DIV -7 / 2 signed -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100 / 7 -> 0x0000000E, REMU -> 0x00000002.
REQ-032 DIVU 5 / 0 -> 0xFFFFFFFF, REMU -> 0x00000005; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-033 en_i dropped 10 cycles into CALC -> IDLE next cycle, no valid_o; following MULL 3 x 5 -> 0x0000000F.
REQ-034 rst_ni pulsed low mid-CALC -> all outputs 0 immediately; no valid_o after release without new request.

Source files
------------

// File: rtl/ibex_defines.sv
// Shared type definitions for the iterative multiply/divide unit.
//   md_op_e    : operation requested by the decoder.
//   md_state_e : sequencing states of the multdiv FSM.
package ibex_defines;

    typedef enum logic [1:0] {
        MD_OP_MULL,
        MD_OP_MULH,
        MD_OP_DIV,
        MD_OP_REM
    } md_op_e;

    typedef enum logic [2:0] {
        MdIdle,
        MdAbsA,
        MdAbsB,
        MdCalc,
        MdNeg,
        MdFinish
    } md_state_e;

    localparam int unsigned MdIterations = 32;

endpackage

// File: rtl/ibex_multdiv_iter.sv
// Iterative 32-bit multiply / divide unit with fixed 36-cycle latency.
// Operands are made non-negative, a 32-step shift-add multiply or restoring
// divide runs on the ALU adder it borrows, and the sign is fixed up at the end.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   en_i                    request, held high until valid_o
//   operator_i              MULL / MULH / DIV / REM
//   signed_mode_i           bit0: op_a signed, bit1: op_b signed
//   op_a_i, op_b_i          operands
//   alu_sel_o               high while this unit drives the shared adder
//   alu_operand_a_o/_b_o    adder inputs {x,1'b1} and {y,1'b0} (or ~{y,1'b0})
//   adder_result_ext_i      adder sum; [32:1] result, [33] carry out
//   valid_o, result_o       one-cycle result strobe and result value
module ibex_multdiv_iter
    import ibex_defines::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  md_op_e      operator_i,
    input  logic [1:0]  signed_mode_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    output logic        alu_sel_o,
    output logic [32:0] alu_operand_a_o,
    output logic [32:0] alu_operand_b_o,
    input  logic [33:0] adder_result_ext_i,
    output logic        valid_o,
    output logic [31:0] result_o
);

    md_state_e   state_q;
    md_op_e      op_q;
    logic        neg_a_q;
    logic        neg_b_q;
    logic        div_zero_q;
    logic [31:0] op_a_q;
    logic [31:0] op_b_q;     // after ABS_B: multiplicand or divisor
    logic [31:0] hi_q;       // product high half / partial remainder
    logic [31:0] lo_q;       // product low half / quotient
    logic [4:0]  cnt_q;
    logic        valid_q;
    logic [31:0] result_q;

    logic [31:0] adder_sum;
    logic        adder_carry;
    logic        unused_adder_lsb;
    logic        is_mul;
    logic [31:0] b_abs;
    logic [31:0] div_shift;
    logic        div_keep;
    logic [63:0] prod;
    logic [63:0] prod_neg;
    logic [31:0] quot_neg;
    logic [31:0] rem_neg;
    logic [31:0] final_res;

    assign adder_sum        = adder_result_ext_i[32:1];
    assign adder_carry      = adder_result_ext_i[33];
    assign unused_adder_lsb = adder_result_ext_i[0];

    assign is_mul = (op_q == MD_OP_MULL) || (op_q == MD_OP_MULH);
    assign b_abs  = neg_b_q ? adder_sum : op_b_q;

    // The bit shifted out of the remainder makes the trial value exceed any
    // 32-bit divisor, so the subtraction must be kept even without carry.
    assign div_shift = {hi_q[30:0], lo_q[31]};
    assign div_keep  = adder_carry | hi_q[31];

    assign prod     = {hi_q, lo_q};
    assign prod_neg = ~prod + 64'd1;
    assign quot_neg = ~lo_q + 32'd1;
    assign rem_neg  = ~hi_q + 32'd1;

    // Sign fix-up done locally: the shared adder is released in NEG.
    always_comb begin
        final_res = hi_q;
        unique case (op_q)
            MD_OP_MULL: final_res = (neg_a_q ^ neg_b_q) ? prod_neg[31:0] : lo_q;
            MD_OP_MULH: final_res = (neg_a_q ^ neg_b_q) ? prod_neg[63:32] : hi_q;
            MD_OP_DIV: begin
                if (div_zero_q) begin
                    final_res = 32'hFFFF_FFFF;
                end else begin
                    final_res = (neg_a_q ^ neg_b_q) ? quot_neg : lo_q;
                end
            end
            MD_OP_REM:  final_res = neg_a_q ? rem_neg : hi_q;
            default:    final_res = hi_q;
        endcase
    end

    // Adder operand formatting for the state currently occupying the adder.
    always_comb begin
        alu_sel_o       = 1'b0;
        alu_operand_a_o = 33'd0;
        alu_operand_b_o = 33'd0;
        unique case (state_q)
            MdAbsA: begin
                alu_sel_o       = 1'b1;
                alu_operand_a_o = {32'd0, 1'b1};
                alu_operand_b_o = ~{op_a_q, 1'b0};
            end
            MdAbsB: begin
                alu_sel_o       = 1'b1;
                alu_operand_a_o = {32'd0, 1'b1};
                alu_operand_b_o = ~{op_b_q, 1'b0};
            end
            MdCalc: begin
                alu_sel_o = 1'b1;
                if (is_mul) begin
                    alu_operand_a_o = {hi_q, 1'b1};
                    alu_operand_b_o = {(lo_q[0] ? op_b_q : 32'd0), 1'b0};
                end else begin
                    alu_operand_a_o = {div_shift, 1'b1};
                    alu_operand_b_o = ~{op_b_q, 1'b0};
                end
            end
            default: begin
                alu_sel_o       = 1'b0;
                alu_operand_a_o = 33'd0;
                alu_operand_b_o = 33'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= MdIdle;
            op_q       <= MD_OP_MULL;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            div_zero_q <= 1'b0;
            op_a_q     <= 32'd0;
            op_b_q     <= 32'd0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            cnt_q      <= 5'd0;
            valid_q    <= 1'b0;
            result_q   <= 32'd0;
        end else begin
            valid_q <= 1'b0;
            if ((state_q != MdIdle) && !en_i) begin
                // Requester withdrew: drop the operation silently.
                state_q <= MdIdle;
            end else begin
                unique case (state_q)
                    MdIdle: begin
                        if (en_i) begin
                            op_q       <= operator_i;
                            neg_a_q    <= signed_mode_i[0] & op_a_i[31];
                            neg_b_q    <= signed_mode_i[1] & op_b_i[31];
                            div_zero_q <= (op_b_i == 32'd0);
                            op_a_q     <= op_a_i;
                            op_b_q     <= op_b_i;
                            hi_q       <= 32'd0;
                            lo_q       <= 32'd0;
                            cnt_q      <= 5'd0;
                            state_q    <= MdAbsA;
                        end
                    end
                    MdAbsA: begin
                        if (neg_a_q) begin
                            op_a_q <= adder_sum;
                        end
                        state_q <= MdAbsB;
                    end
                    MdAbsB: begin
                        // Multiply: lo holds the multiplier, op_b the multiplicand.
                        // Divide: lo holds the dividend, op_b the divisor.
                        op_b_q  <= is_mul ? op_a_q : b_abs;
                        lo_q    <= is_mul ? b_abs : op_a_q;
                        hi_q    <= 32'd0;
                        cnt_q   <= 5'd0;
                        state_q <= MdCalc;
                    end
                    MdCalc: begin
                        if (is_mul) begin
                            hi_q <= {adder_carry, adder_sum[31:1]};
                            lo_q <= {adder_sum[0], lo_q[31:1]};
                        end else begin
                            hi_q <= div_keep ? adder_sum : div_shift;
                            lo_q <= {lo_q[30:0], div_keep};
                        end
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'(MdIterations - 1)) begin
                            state_q <= MdNeg;
                        end
                    end
                    MdNeg: begin
                        hi_q    <= final_res;
                        state_q <= MdFinish;
                    end
                    MdFinish: begin
                        result_q <= hi_q;
                        valid_q  <= 1'b1;
                        state_q  <= MdIdle;
                    end
                    default: state_q <= MdIdle;
                endcase
            end
        end
    end

    assign valid_o  = valid_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_ibex_multdiv_iter.sv
module tb_ibex_multdiv_iter;
    import ibex_defines::*;

    logic        clk_i;
    logic        rst_ni;
    logic        en_i;
    md_op_e      operator_i;
    logic [1:0]  signed_mode_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        alu_sel_o;
    logic [32:0] alu_operand_a_o;
    logic [32:0] alu_operand_b_o;
    logic [33:0] adder_result_ext_i;
    logic        valid_o;
    logic [31:0] result_o;

    int total;
    int bad;

    typedef struct packed {
        md_op_e      op;
        logic [1:0]  mode;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    ibex_multdiv_iter dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .en_i               (en_i),
        .operator_i         (operator_i),
        .signed_mode_i      (signed_mode_i),
        .op_a_i             (op_a_i),
        .op_b_i             (op_b_i),
        .alu_sel_o          (alu_sel_o),
        .alu_operand_a_o    (alu_operand_a_o),
        .alu_operand_b_o    (alu_operand_b_o),
        .adder_result_ext_i (adder_result_ext_i),
        .valid_o            (valid_o),
        .result_o           (result_o)
    );

    // Model of the shared ALU adder.
    assign adder_result_ext_i = {1'b0, alu_operand_a_o} + {1'b0, alu_operand_b_o};

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Issue one request and wait for valid_o; lat counts posedges after acceptance.
    task automatic run_op(input md_op_e op, input logic [1:0] mode, input logic [31:0] a,
                          input logic [31:0] b, input bit keep_en,
                          output logic [31:0] res, output int lat);
        @(negedge clk_i);
        en_i          = 1'b1;
        operator_i    = op;
        signed_mode_i = mode;
        op_a_i        = a;
        op_b_i        = b;
        @(posedge clk_i);
        lat = 0;
        res = 32'hDEAD_BEEF;
        do begin
            @(posedge clk_i);
            #1;
            lat++;
        end while (!valid_o && lat < 100);
        if (valid_o) res = result_o;
        if (!keep_en) begin
            @(negedge clk_i);
            en_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        en_i   = 1'b0;
        operator_i    = MD_OP_MULL;
        signed_mode_i = 2'b00;
        op_a_i = 32'd0;
        op_b_i = 32'd0;
        repeat (2) @(posedge clk_i);
        #1;
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset valid_o: got %b want 0", valid_o); end
        total++; if (result_o !== 32'd0) begin bad++; $display("FAIL reset result_o: got %h want 0", result_o); end
        total++; if (alu_sel_o !== 1'b0) begin bad++; $display("FAIL reset alu_sel_o: got %b want 0", alu_sel_o); end
        total++; if (alu_operand_a_o !== 33'd0) begin bad++; $display("FAIL reset operand_a: got %h want 0", alu_operand_a_o); end
        total++; if (alu_operand_b_o !== 33'd0) begin bad++; $display("FAIL reset operand_b: got %h want 0", alu_operand_b_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_mul();
        vec_t v [7];
        logic [31:0] res;
        int lat;
        v[0] = '{MD_OP_MULL, 2'b00, 32'd7,         32'd6,         32'h0000_002A};
        v[1] = '{MD_OP_MULL, 2'b11, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE};
        v[2] = '{MD_OP_MULH, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        v[3] = '{MD_OP_MULH, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        v[4] = '{MD_OP_MULH, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        v[5] = '{MD_OP_MULH, 2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        v[6] = '{MD_OP_MULL, 2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F};
        for (int i = 0; i < 7; i++) begin
            run_op(v[i].op, v[i].mode, v[i].a, v[i].b, 1'b0, res, lat);
            total++;
            if (res !== v[i].exp) begin
                bad++; $display("FAIL mul[%0d] result: got %h want %h", i, res, v[i].exp);
            end
            total++;
            if (lat !== 36) begin
                bad++; $display("FAIL mul[%0d] latency: got %0d want 36", i, lat);
            end
            if (i == 0) begin
                @(posedge clk_i);
                #1;
                total++;
                if (valid_o !== 1'b0) begin
                    bad++; $display("FAIL valid pulse width: got %b want 0", valid_o);
                end
            end
        end
    endtask

    task automatic test_div();
        vec_t v [4];
        logic [31:0] res;
        int lat;
        v[0] = '{MD_OP_DIV, 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD};
        v[1] = '{MD_OP_REM, 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF};
        v[2] = '{MD_OP_DIV, 2'b00, 32'd100,       32'd7, 32'h0000_000E};
        v[3] = '{MD_OP_REM, 2'b00, 32'd100,       32'd7, 32'h0000_0002};
        for (int i = 0; i < 4; i++) begin
            run_op(v[i].op, v[i].mode, v[i].a, v[i].b, 1'b0, res, lat);
            total++;
            if (res !== v[i].exp) begin
                bad++; $display("FAIL div[%0d] result: got %h want %h", i, res, v[i].exp);
            end
            total++;
            if (lat !== 36) begin
                bad++; $display("FAIL div[%0d] latency: got %0d want 36", i, lat);
            end
        end
    endtask

    task automatic test_div_special();
        vec_t v [6];
        logic [31:0] res;
        int lat;
        v[0] = '{MD_OP_DIV, 2'b00, 32'd5,         32'd0,         32'hFFFF_FFFF};
        v[1] = '{MD_OP_REM, 2'b00, 32'd5,         32'd0,         32'h0000_0005};
        v[2] = '{MD_OP_DIV, 2'b11, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFFF};
        v[3] = '{MD_OP_REM, 2'b11, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8};
        v[4] = '{MD_OP_DIV, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        v[5] = '{MD_OP_REM, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        for (int i = 0; i < 6; i++) begin
            run_op(v[i].op, v[i].mode, v[i].a, v[i].b, 1'b0, res, lat);
            total++;
            if (res !== v[i].exp) begin
                bad++; $display("FAIL divspecial[%0d] result: got %h want %h", i, res, v[i].exp);
            end
            total++;
            if (lat !== 36) begin
                bad++; $display("FAIL divspecial[%0d] latency: got %0d want 36", i, lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        int lat;
        run_op(MD_OP_MULL, 2'b00, 32'd3, 32'd4, 1'b1, res, lat);
        total++;
        if (res !== 32'd12) begin bad++; $display("FAIL b2b first result: got %h want 0000000c", res); end
        run_op(MD_OP_DIV, 2'b00, 32'd9, 32'd2, 1'b0, res, lat);
        total++;
        if (res !== 32'd4) begin bad++; $display("FAIL b2b second result: got %h want 00000004", res); end
        total++;
        if (lat !== 36) begin bad++; $display("FAIL b2b second latency: got %0d want 36", lat); end
    endtask

    task automatic test_abort();
        logic [31:0] res;
        int lat;
        int seen;
        @(negedge clk_i);
        en_i          = 1'b1;
        operator_i    = MD_OP_MULL;
        signed_mode_i = 2'b00;
        op_a_i        = 32'd1000;
        op_b_i        = 32'd1000;
        @(posedge clk_i);                 // accepted
        repeat (2) @(posedge clk_i);      // ABS_A, ABS_B -> CALC
        repeat (10) @(posedge clk_i);     // 10 iterations
        @(negedge clk_i);
        en_i = 1'b0;
        @(posedge clk_i);
        #1;
        total++;
        if (alu_sel_o !== 1'b0) begin bad++; $display("FAIL abort idle alu_sel_o: got %b want 0", alu_sel_o); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i);
            #1;
            if (valid_o) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL abort no valid: got %0d pulses want 0", seen); end
        run_op(MD_OP_MULL, 2'b00, 32'd3, 32'd5, 1'b0, res, lat);
        total++;
        if (res !== 32'h0000_000F) begin bad++; $display("FAIL abort follow result: got %h want 0000000f", res); end
        total++;
        if (lat !== 36) begin bad++; $display("FAIL abort follow latency: got %0d want 36", lat); end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk_i);
        en_i          = 1'b1;
        operator_i    = MD_OP_DIV;
        signed_mode_i = 2'b00;
        op_a_i        = 32'd77;
        op_b_i        = 32'd3;
        repeat (12) @(posedge clk_i);
        #2;
        total++;
        if (alu_sel_o !== 1'b1) begin bad++; $display("FAIL midcalc alu_sel_o: got %b want 1", alu_sel_o); end
        rst_ni = 1'b0;
        #1;
        total++;
        if (result_o !== 32'd0) begin bad++; $display("FAIL rstmid result_o: got %h want 0", result_o); end
        total++;
        if (alu_sel_o !== 1'b0) begin bad++; $display("FAIL rstmid alu_sel_o: got %b want 0", alu_sel_o); end
        total++;
        if ({alu_operand_a_o, alu_operand_b_o} !== 66'd0) begin
            bad++; $display("FAIL rstmid operands: got %h %h want 0 0", alu_operand_a_o, alu_operand_b_o);
        end
        total++;
        if (valid_o !== 1'b0) begin bad++; $display("FAIL rstmid valid_o: got %b want 0", valid_o); end
        en_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i);
            #1;
            if (valid_o) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL rstmid no valid: got %0d pulses want 0", seen); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_mul();
        test_div();
        test_div_special();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
